// File: rtl/dual_port_mem_responder.sv
// Dual-port word memory: a read-only fetch port and a load/store port, one-cycle read latency.
// Define MEM_MMIO_EN to map a cycle counter and LED register at 0xFFFF_FF00 on the ldst port.
module dual_port_mem_responder #(
    parameter int IW          = 32,
    parameter int DEPTH_WORDS = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] i_pc_addr,
    input  logic          i_pc_rd,
    input  logic [3:0]    i_pc_byte_en,
    output logic [IW-1:0] o_pc_rddata,
    input  logic [IW-1:0] i_ldst_addr,
    input  logic          i_ldst_rd,
    input  logic          i_ldst_wr,
    input  logic [IW-1:0] i_ldst_wrdata,
    input  logic [3:0]    i_ldst_byte_en,
    output logic [IW-1:0] o_ldst_rddata,
    output logic          o_ldst_err,
    output logic [IW-1:0] o_mmio_led
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam longint unsigned LIMIT = longint'(DEPTH_WORDS) * 4;

    logic [IW-1:0] mem_q [DEPTH_WORDS];

    logic [IW-1:0] pc_rddata_q, pc_rddata_d;
    logic [IW-1:0] ldst_rddata_q, ldst_rddata_d;
    logic          ldst_err_q, ldst_err_d;
    logic [IW-1:0] ls_word;

    logic [AW-1:0] pc_idx, ls_idx;
    logic          pc_inr, ls_inr, ls_bad_rng, ls_mis;

    assign pc_idx = i_pc_addr[AW+1:2];
    assign ls_idx = i_ldst_addr[AW+1:2];
    assign pc_inr = 64'(i_pc_addr) < LIMIT;
    assign ls_inr = 64'(i_ldst_addr) < LIMIT;

    // Misaligned accesses are flagged but still hit the word selected by addr[AW+1:2].
    assign ls_mis = (i_ldst_byte_en == 4'b0011 && i_ldst_addr[0]) ||
                    (i_ldst_byte_en == 4'b1111 && i_ldst_addr[1:0] != 2'b00);

`ifdef MEM_MMIO_EN
    logic [31:0]   cnt_q, cnt_d;
    logic [IW-1:0] led_q, led_d;
    logic          ls_win, led_sel;

    assign ls_win     = &i_ldst_addr[IW-1:8];
    assign led_sel    = ls_win && i_ldst_addr[7:0] == 8'h04;
    assign ls_bad_rng = !ls_inr && !ls_win;
    assign cnt_d      = cnt_q + 32'd1;
    assign o_mmio_led = led_q;

    always_comb begin
        led_d = led_q;
        if (i_ldst_wr && led_sel)
            for (int k = 0; k < 4; k++)
                if (i_ldst_byte_en[k]) led_d[8*k +: 8] = i_ldst_wrdata[8*k +: 8];
    end

    always_comb begin
        ls_word = '0;
        if (ls_inr)                               ls_word = mem_q[ls_idx];
        else if (ls_win && i_ldst_addr[7:0] == 8'h00) ls_word = IW'(cnt_q);
        else if (led_sel)                         ls_word = led_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            led_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end
`else
    assign ls_bad_rng = !ls_inr;
    assign o_mmio_led = '0;

    always_comb begin
        ls_word = '0;
        if (ls_inr) ls_word = mem_q[ls_idx];
    end
`endif

    always_comb begin
        pc_rddata_d   = pc_rddata_q;
        ldst_rddata_d = ldst_rddata_q;
        if (i_pc_rd)   pc_rddata_d   = pc_inr ? mem_q[pc_idx] : '0;
        if (i_ldst_rd) ldst_rddata_d = ls_word;
        ldst_err_d = (i_ldst_rd || i_ldst_wr) && (ls_bad_rng || ls_mis);
    end

    // Array is deliberately left out of the reset branch: contents survive reset,
    // but no write is accepted while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_rddata_q   <= '0;
            ldst_rddata_q <= '0;
            ldst_err_q    <= 1'b0;
        end else begin
            pc_rddata_q   <= pc_rddata_d;
            ldst_rddata_q <= ldst_rddata_d;
            ldst_err_q    <= ldst_err_d;
            if (i_ldst_wr && ls_inr)
                for (int k = 0; k < 4; k++)
                    if (i_ldst_byte_en[k]) mem_q[ls_idx][8*k +: 8] <= i_ldst_wrdata[8*k +: 8];
        end
    end

    assign o_pc_rddata   = pc_rddata_q;
    assign o_ldst_rddata = ldst_rddata_q;
    assign o_ldst_err    = ldst_err_q;

    logic unused_bits;
    assign unused_bits = ^{i_pc_byte_en, i_pc_addr[1:0]};
endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Directed bench for dual_port_mem_responder (default DEPTH 4096, IW 32); covers MEM_MMIO_EN either way.
module tb_dual_port_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_addr = '0;
    logic        pc_rd = 1'b0;
    logic [3:0]  pc_be = 4'hF;
    logic [31:0] pc_rddata;
    logic [31:0] ls_addr = '0;
    logic        ls_rd = 1'b0, ls_wr = 1'b0;
    logic [31:0] ls_wrdata = '0;
    logic [3:0]  ls_be = 4'hF;
    logic [31:0] ls_rddata;
    logic        ls_err;
    logic [31:0] led;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    dual_port_mem_responder dut (
        .clk(clk), .reset(reset),
        .i_pc_addr(pc_addr), .i_pc_rd(pc_rd), .i_pc_byte_en(pc_be), .o_pc_rddata(pc_rddata),
        .i_ldst_addr(ls_addr), .i_ldst_rd(ls_rd), .i_ldst_wr(ls_wr),
        .i_ldst_wrdata(ls_wrdata), .i_ldst_byte_en(ls_be),
        .o_ldst_rddata(ls_rddata), .o_ldst_err(ls_err), .o_mmio_led(led)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        ls_addr = a; ls_wrdata = d; ls_be = be; ls_wr = 1'b1; ls_rd = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [3:0] be);
        ls_addr = a; ls_be = be; ls_rd = 1'b1; ls_wr = 1'b0;
    endtask

    task automatic idle();
        ls_rd = 1'b0; ls_wr = 1'b0; pc_rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] c1, c2;
        tick(); tick();
        check("rst_pc", pc_rddata, 32'h0);
        check("rst_ls", ls_rddata, 32'h0);
        check("rst_err", {31'b0, ls_err}, 32'h0);
        check("rst_led", led, 32'h0);
        reset = 1'b1;

        store(32'h10, 32'hDEADBEEF, 4'hF); tick();
        check("st_word_err", {31'b0, ls_err}, 32'h0);
        load(32'h10, 4'hF); tick();
        check("ld_word", ls_rddata, 32'hDEADBEEF);

        // Byte store colliding with a fetch of the same word: fetch sees the old word
        store(32'h10, 32'h000000AA, 4'b0001); pc_rd = 1'b1; pc_addr = 32'h10; tick();
        check("pc_rbw", pc_rddata, 32'hDEADBEEF);
        check("ls_hold", ls_rddata, 32'hDEADBEEF);
        ls_wr = 1'b0; tick();
        check("pc_after_byte", pc_rddata, 32'hDEADBEAA);

        pc_rd = 1'b0;
        store(32'h10, 32'h11223344, 4'hF); ls_rd = 1'b1; tick();
        check("rdwr_old", ls_rddata, 32'hDEADBEAA);
        ls_wr = 1'b0; tick();
        check("rdwr_new", ls_rddata, 32'h11223344);
        check("pc_hold", pc_rddata, 32'hDEADBEAA);

        store(32'h14, 32'hCAFEF00D, 4'hF); tick();
        store(32'h15, 32'h00007777, 4'b0011); tick();
        check("mis_half_err", {31'b0, ls_err}, 32'h1);
        load(32'h14, 4'hF); tick();
        check("mis_half_err_end", {31'b0, ls_err}, 32'h0);
        check("mis_half_data", ls_rddata, 32'hCAFE7777);

        store(32'h10, 32'hFFFFFFFF, 4'b0000); tick();
        load(32'h10, 4'hF); tick();
        check("be0_nowrite", ls_rddata, 32'h11223344);

        load(32'h12, 4'hF); tick();
        check("mis_word_err", {31'b0, ls_err}, 32'h1);
        check("mis_word_data", ls_rddata, 32'h11223344);
        load(32'h4000, 4'hF); tick();
        check("oor_data", ls_rddata, 32'h0);
        check("oor_err", {31'b0, ls_err}, 32'h1);
        idle(); tick();
        check("oor_err_pulse", {31'b0, ls_err}, 32'h0);

        store(32'h4010, 32'hBADBAD00, 4'hF); tick();
        check("oor_wr_err", {31'b0, ls_err}, 32'h1);
        load(32'h10, 4'hF); tick();
        check("oor_wr_ignored", ls_rddata, 32'h11223344);

        store(32'h3FFC, 32'hA5A5A5A5, 4'hF); tick();
        ls_wr = 1'b0; pc_rd = 1'b1; pc_addr = 32'h3FFC; tick();
        check("pc_last_word", pc_rddata, 32'hA5A5A5A5);
        pc_addr = 32'h4000; tick();
        check("pc_oor", pc_rddata, 32'h0);

        // Back-to-back on both ports
        pc_addr = 32'h10; load(32'h14, 4'hF); tick();
        check("b2b_ls0", ls_rddata, 32'hCAFE7777);
        check("b2b_pc0", pc_rddata, 32'h11223344);
        pc_addr = 32'h14; load(32'h3FFC, 4'hF); tick();
        check("b2b_ls1", ls_rddata, 32'hA5A5A5A5);
        check("b2b_pc1", pc_rddata, 32'hCAFE7777);
        idle();

`ifdef MEM_MMIO_EN
        store(32'hFFFFFF04, 32'h000000FF, 4'b0001); tick();
        check("led_err", {31'b0, ls_err}, 32'h0);
        check("led_val", led, 32'h000000FF);
        load(32'hFFFFFF00, 4'hF); tick();
        c1 = ls_rddata;
        check("cnt_err", {31'b0, ls_err}, 32'h0);
        tick(); tick();
        c2 = ls_rddata;
        check("cnt_delta", c2 - c1, 32'd2);
        load(32'hFFFFFF08, 4'hF); tick();
        check("win_other", ls_rddata, 32'h0);
        check("win_other_err", {31'b0, ls_err}, 32'h0);
        ls_rd = 1'b0; pc_rd = 1'b1; pc_addr = 32'hFFFFFF04; tick();
        check("pc_win", pc_rddata, 32'h0);
        pc_rd = 1'b0;
`else
        load(32'hFFFFFF00, 4'hF); tick();
        check("nowin_data", ls_rddata, 32'h0);
        check("nowin_err", {31'b0, ls_err}, 32'h1);
        store(32'hFFFFFF04, 32'h000000FF, 4'b0001); tick();
        check("nowin_wr_err", {31'b0, ls_err}, 32'h1);
        check("nowin_led", led, 32'h0);
`endif

        idle();
        store(32'h20, 32'h12345678, 4'hF); tick();
        load(32'h20, 4'hF); pc_rd = 1'b1; pc_addr = 32'h20; tick();
        check("pre_rst_ls", ls_rddata, 32'h12345678);
        check("pre_rst_pc", pc_rddata, 32'h12345678);
        // Keep strobes active through reset; none may take effect
        ls_wr = 1'b1; ls_wrdata = 32'h0; ls_addr = 32'h21; ls_be = 4'b0001;
        #2 reset = 1'b0;
        #1;
        check("async_rst_pc", pc_rddata, 32'h0);
        check("async_rst_ls", ls_rddata, 32'h0);
        check("async_rst_err", {31'b0, ls_err}, 32'h1 & 32'h0);
        check("async_rst_led", led, 32'h0);
        tick(); tick();
        check("rst_hold_pc", pc_rddata, 32'h0);
        check("rst_hold_err", {31'b0, ls_err}, 32'h0);
        reset = 1'b1;
        idle(); load(32'h20, 4'hF); tick();
        check("post_rst_mem", ls_rddata, 32'h12345678);
        check("post_rst_err", {31'b0, ls_err}, 32'h0);
        idle(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
